// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, PPROT bit meanings and default bus widths.
package apb_pkg;

    localparam int unsigned APB_DEF_ADDR_W = 12;
    localparam int unsigned APB_DEF_DATA_W = 32;

    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS wait-state counter: cleared before ACCESS, counts stalled cycles, flags the cycle that hits the limit.
module apb_master_timeout #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The stalled cycle that would bring the count to the limit aborts the transfer.
    assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB4 requester: valid/ready command in, SETUP/ACCESS on APB, valid/ready response out.
// Optional ACCESS timeout abort is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_DEF_ADDR_W,
    parameter int unsigned DATA_W      = APB_DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                  PCLK_i,
    input  logic                  PRESET_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [DATA_W-1:0]     cmd_wdata_i,
    input  logic [DATA_W/8-1:0]   cmd_strb_i,
    input  logic [2:0]            cmd_prot_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  PSEL_o,
    output logic                  PENABLE_o,
    output logic                  PWRITE_o,
    output logic [ADDR_W-1:0]     PADDR_o,
    output logic [DATA_W-1:0]     PWDATA_o,
    output logic [DATA_W/8-1:0]   PSTRB_o,
    output logic [2:0]            PPROT_o,
    input  logic [DATA_W-1:0]     PRDATA_i,
    input  logic                  PREADY_i,
    input  logic                  PSLVERR_i
);

    localparam int unsigned STRB_W = DATA_W / 8;

    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("apb_master: DATA_W must be a multiple of 8");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYC must be at least 1");
    end

    apb_state_e          state_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [2:0]          pprot_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

`ifdef APB_MASTER_TIMEOUT_EN
    logic timeout_expired;

    apb_master_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (PCLK_i),
        .rst_i     (PRESET_i),
        .clear_i   (state_q == SETUP),
        .enable_i  ((state_q == ACCESS) && !PREADY_i),
        .expired_o (timeout_expired)
    );
`endif

    // Transfer sequencer; all APB and response signals are registered here.
    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        state_q   <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= cmd_write_i;
                        paddr_q   <= cmd_addr_i;
                        pwdata_q  <= cmd_write_i ? cmd_wdata_i : '0;
                        pstrb_q   <= cmd_write_i ? cmd_strb_i : '0;
                        pprot_q   <= cmd_prot_i;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY_i) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rdata_q   <= pwrite_q ? '0 : PRDATA_i;
                        err_q     <= PSLVERR_i;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (timeout_expired) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign PSEL_o      = psel_q;
    assign PENABLE_o   = penable_q;
    assign PWRITE_o    = pwrite_q;
    assign PADDR_o     = paddr_q;
    assign PWDATA_o    = pwdata_q;
    assign PSTRB_o     = pstrb_q;
    assign PPROT_o     = pprot_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: the bench plays the APB slave and keeps a word-array memory model.
module tb_apb_master;
    import apb_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [DW-1:0] cmd_wdata_i = '0;
    logic [SW-1:0] cmd_strb_i = '0;
    logic [2:0]    cmd_prot_i = '0;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] PRDATA_i = '0;
    logic          PREADY_i = 1'b0, PSLVERR_i = 1'b0;
    logic          cmd_ready_o, rsp_valid_o, rsp_err_o;
    logic [DW-1:0] rsp_rdata_o, PWDATA_o;
    logic          PSEL_o, PENABLE_o, PWRITE_o;
    logic [AW-1:0] PADDR_o;
    logic [SW-1:0] PSTRB_o;
    logic [2:0]    PPROT_o;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] mem [16];

    always #5 clk = ~clk;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .PCLK_i(clk), .PRESET_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .cmd_prot_i(cmd_prot_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o), .PADDR_o(PADDR_o),
        .PWDATA_o(PWDATA_o), .PSTRB_o(PSTRB_o), .PPROT_o(PPROT_o),
        .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
    );

    // Scramble command inputs while busy so any late sampling shows up on the bus.
    task automatic scramble_cmd(input logic valid);
        cmd_valid_i = valid;
        cmd_write_i = 1'($urandom);
        cmd_addr_i  = AW'($urandom);
        cmd_wdata_i = DW'($urandom);
        cmd_strb_i  = SW'($urandom);
        cmd_prot_i  = 3'($urandom);
    endtask

    // One complete transfer; called at a negedge with the DUT idle, returns at the negedge after the response.
    task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] sb, input int waits, input logic serr, input int bp);
        logic [2:0]    pr = 3'($urandom);
        int            idx = int'(a[5:2]);
        logic [DW-1:0] exp_wd = wr ? wd : '0;
        logic [SW-1:0] exp_sb = wr ? sb : '0;
        logic [DW-1:0] exp_rd = wr ? '0 : mem[idx];
        logic [AW+DW+SW+3:0] exp_bus = {wr, a, exp_wd, exp_sb, pr};

        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL idle_ready: got %b want 1", cmd_ready_o);
        end
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a;
        cmd_wdata_i = wd; cmd_strb_i = sb; cmd_prot_i = pr;
        @(negedge clk);
        scramble_cmd(1'($urandom));

        checks++;
        if ({PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o} !== 4'b1000) begin
            errors++; $display("FAIL setup_ctl: got %b want 1000", {PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o});
        end
        checks++;
        if ({PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o, PPROT_o} !== exp_bus) begin
            errors++; $display("FAIL setup_bus: got %h want %h", {PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o, PPROT_o}, exp_bus);
        end
        PREADY_i = 1'($urandom); PSLVERR_i = 1'($urandom); PRDATA_i = DW'($urandom);
        @(negedge clk);

        for (int w = 0; w <= waits; w++) begin
            checks++;
            if ({PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o} !== 4'b1100) begin
                errors++; $display("FAIL access_ctl[%0d]: got %b want 1100", w, {PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o});
            end
            checks++;
            if ({PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o, PPROT_o} !== exp_bus) begin
                errors++; $display("FAIL access_bus[%0d]: got %h want %h", w, {PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o, PPROT_o}, exp_bus);
            end
            if (w == waits) begin
                PREADY_i = 1'b1; PSLVERR_i = serr; PRDATA_i = mem[idx];
            end else begin
                PREADY_i = 1'b0; PSLVERR_i = 1'($urandom); PRDATA_i = DW'($urandom);
            end
            @(negedge clk);
        end
        if (wr && !serr) begin
            for (int k = 0; k < int'(SW); k++)
                if (sb[k]) mem[idx][8*k +: 8] = wd[8*k +: 8];
        end
        PREADY_i = 1'($urandom); PSLVERR_i = 1'($urandom); PRDATA_i = DW'($urandom);

        for (int b = 0; b <= bp; b++) begin
            checks++;
            if ({PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o} !== 4'b0001) begin
                errors++; $display("FAIL resp_ctl[%0d]: got %b want 0001", b, {PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o});
            end
            checks++;
            if ({rsp_rdata_o, rsp_err_o} !== {exp_rd, serr}) begin
                errors++; $display("FAIL resp_data[%0d]: got %h/%b want %h/%b", b, rsp_rdata_o, rsp_err_o, exp_rd, serr);
            end
            if (b == bp) begin
                rsp_ready_i = 1'b1; cmd_valid_i = 1'b0;
            end
            @(negedge clk);
        end
        rsp_ready_i = 1'b0; PREADY_i = 1'b0; PSLVERR_i = 1'b0;

        checks++;
        if ({PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o} !== 4'b0010) begin
            errors++; $display("FAIL post_ctl: got %b want 0010", {PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o});
        end
        checks++;
        if ({PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o, PPROT_o} !== exp_bus) begin
            errors++; $display("FAIL post_bus_hold: got %h want %h", {PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o, PPROT_o}, exp_bus);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o} !== {1'b1, 1'b0, {DW{1'b0}}, 1'b0}) begin
            errors++; $display("FAIL reset_rsp: got %b/%b/%h/%b want 1/0/0/0", cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
        end
        checks++;
        if ({PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o, PPROT_o} !== '0) begin
            errors++; $display("FAIL reset_apb: got %h want 0", {PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o, PPROT_o});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_write();
        txn(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0);
    endtask

    task automatic test_readback();
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL model_mem: got %h want deadbeef", mem[4]);
        end
        txn(1'b0, 12'h010, 32'h0, 4'hF, 0, 1'b0, 0);
    endtask

    task automatic test_wait_states();
        txn(1'b1, 12'h014, DW'($urandom), 4'b0101, 3, 1'b0, 0);
        txn(1'b0, 12'h014, DW'($urandom), 4'hF, 3, 1'b0, 0);
    endtask

    task automatic test_err_backpressure();
        txn(1'b0, 12'h010, 32'h0, 4'h0, 1, 1'b1, 5);
        txn(1'b1, 12'h018, DW'($urandom), 4'hF, 0, 1'b1, 5);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            txn(1'($urandom), AW'({$urandom_range(0, 15), 2'b00}), DW'($urandom), SW'($urandom), 0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            txn(1'($urandom), AW'({$urandom_range(0, 15), 2'b00}), DW'($urandom), SW'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
    endtask

    task automatic test_reset_mid_access();
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 12'h010;
        cmd_prot_i = PPROT_PRIV | PPROT_NONSEC;
        @(negedge clk);
        cmd_valid_i = 1'b0; PREADY_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; PREADY_i = 1'b1; PRDATA_i = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if ({PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o} !== 4'b0010) begin
            errors++; $display("FAIL reset_mid_ctl: got %b want 0010", {PSEL_o, PENABLE_o, cmd_ready_o, rsp_valid_o});
        end
        rst = 1'b0; PREADY_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 1'b0, 1'b0, {DW{1'b0}}}) begin
            errors++; $display("FAIL reset_mid_norsp: got %b/%b/%b/%h want 1/0/0/0", cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
    endtask

    task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 12'h020;
        cmd_wdata_i = 32'h12345678; cmd_strb_i = 4'hF; cmd_prot_i = PPROT_INSTR;
        @(negedge clk);
        cmd_valid_i = 1'b0; PREADY_i = 1'b0; PRDATA_i = 32'hFFFFFFFF;
        @(negedge clk);
        for (int w = 0; w < int'(TO); w++) begin
            checks++;
            if ({PSEL_o, PENABLE_o, rsp_valid_o} !== 3'b110) begin
                errors++; $display("FAIL timeout_access[%0d]: got %b want 110", w, {PSEL_o, PENABLE_o, rsp_valid_o});
            end
            @(negedge clk);
        end
        checks++;
        if ({PSEL_o, PENABLE_o, rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0011, {DW{1'b0}}}) begin
            errors++; $display("FAIL timeout_resp: got %b%b%b%b/%h want 0011/0", PSEL_o, PENABLE_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        // Completion on the limit cycle wins over the abort.
        txn(1'b0, 12'h010, 32'h0, 4'h0, int'(TO) - 1, 1'b0, 0);
`else
        txn(1'b1, 12'h024, DW'($urandom), 4'hF, 9, 1'b0, 1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        @(negedge clk);
        test_reset();
        test_basic_write();
        test_readback();
        test_wait_states();
        test_err_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
